// File: rtl/dpram_sync_clr_if.sv
// Request/response bundle for dpram_sync_clr: write port, read port and status.
// The master drives requests; the slave (the RAM) returns registered read data and status.
interface dpram_sync_clr_if #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 3
);
  logic                 wr;
  logic [WIDTH/8-1:0]   be;
  logic [ADDR-1:0]      wraddr;
  logic [WIDTH-1:0]     din;
  logic                 rd;
  logic [ADDR-1:0]      rdaddr;
  logic [WIDTH-1:0]     dout;
  logic                 rd_valid;
  logic                 busy;
  logic                 oor;

  modport master (
    output wr, be, wraddr, din, rd, rdaddr,
    input  dout, rd_valid, busy, oor
  );

  modport slave (
    input  wr, be, wraddr, din, rd, rdaddr,
    output dout, rd_valid, busy, oor
  );
endinterface

// File: rtl/dpram_sync_clr.sv
// Single-clock dual-port RAM with byte-enable writes, selectable read-during-write
// policy and a clear engine that zeroes every word after each reset.
module dpram_sync_clr #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR     = 3,
  parameter int RDW_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  dpram_sync_clr_if.slave  bus
);
  localparam int              NB      = WIDTH / 8;
  localparam logic [ADDR:0]   DEPTH_W = (ADDR+1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST    = ADDR'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_q;
  logic [ADDR-1:0]   ptr_q;
  logic              busy_q;
  logic              rd_valid_q;
  logic              oor_q;
  logic [WIDTH-1:0]  dout_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              wr_ok;
  logic              rd_ok;
  logic              oor_d;
  logic [ADDR-1:0]   rd_idx;
  logic [WIDTH-1:0]  rd_old;
  logic [WIDTH-1:0]  dout_d;

  function automatic logic in_range(input logic [ADDR-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_w,
                                                   input logic [WIDTH-1:0] new_w,
                                                   input logic [NB-1:0]    en);
    logic [WIDTH-1:0] r;
    r = old_w;
    for (int k = 0; k < NB; k++) begin
      if (en[k]) r[8*k +: 8] = new_w[8*k +: 8];
    end
    return r;
  endfunction

  always_comb begin
    wr_ok  = (state_q == IDLE) && bus.wr && in_range(bus.wraddr);
    rd_ok  = (state_q == IDLE) && bus.rd && in_range(bus.rdaddr);
    oor_d  = (state_q == IDLE) &&
             ((bus.wr && !in_range(bus.wraddr)) || (bus.rd && !in_range(bus.rdaddr)));
    rd_idx = in_range(bus.rdaddr) ? bus.rdaddr : '0;
    rd_old = mem[rd_idx];
    dout_d = '0;
    // Write-first forwards the merged word; out-of-range reads return zero.
    if (rd_ok) begin
      if (RDW_MODE != 0 && wr_ok && bus.wraddr == bus.rdaddr)
        dout_d = merge_bytes(rd_old, bus.din, bus.be);
      else
        dout_d = rd_old;
    end
  end

  // Array storage is never reset; the clear engine owns it while in CLEAR.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.be[k]) mem[bus.wraddr][8*k +: 8] <= bus.din[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      ptr_q      <= '0;
      busy_q     <= 1'b1;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      oor_q      <= 1'b0;
      case (state_q)
        CLEAR: begin
          // Pointer stops at the last word instead of wrapping.
          if (ptr_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        IDLE: begin
          oor_q <= oor_d;
          if (bus.rd) begin
            rd_valid_q <= 1'b1;
            dout_q     <= dout_d;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign bus.dout     = dout_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
  assign bus.oor      = oor_q;
endmodule

// File: tb/tb_dpram_sync_clr.sv
// Bench for dpram_sync_clr: two 8-word instances (read-first / write-first) share stimulus
// and are checked against an array model; a 6-word instance covers mid-clear reset and out-of-range.
module tb_dpram_sync_clr;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst2;

  dpram_sync_clr_if #(.WIDTH(16), .ADDR(3)) if0 ();
  dpram_sync_clr_if #(.WIDTH(16), .ADDR(3)) if1 ();
  dpram_sync_clr_if #(.WIDTH(16), .ADDR(3)) if2 ();

  assign if1.wr     = if0.wr;
  assign if1.be     = if0.be;
  assign if1.wraddr = if0.wraddr;
  assign if1.din    = if0.din;
  assign if1.rd     = if0.rd;
  assign if1.rdaddr = if0.rdaddr;

  dpram_sync_clr #(.WIDTH(16), .DEPTH(8), .ADDR(3), .RDW_MODE(0)) u0 (.clk(clk), .rst(rst),  .bus(if0));
  dpram_sync_clr #(.WIDTH(16), .DEPTH(8), .ADDR(3), .RDW_MODE(1)) u1 (.clk(clk), .rst(rst),  .bus(if1));
  dpram_sync_clr #(.WIDTH(16), .DEPTH(6), .ADDR(3), .RDW_MODE(0)) u2 (.clk(clk), .rst(rst2), .bus(if2));

  int checks   = 0;
  int failures = 0;

  // Reference model for the 8-word pair
  logic [15:0] mm [8];
  int          clr_left;
  logic [15:0] ed0, ed1;
  logic        erv, eoor, ebusy;

  typedef struct {
    logic        wr;
    logic [1:0]  be;
    logic [2:0]  wa;
    logic [15:0] din;
    logic        rd;
    logic [2:0]  ra;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        rv;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_dout_rf"}, {16'h0, if0.dout}, {16'h0, ed0});
    chk({tag, "_dout_wf"}, {16'h0, if1.dout}, {16'h0, ed1});
    chk({tag, "_rv_rf"},   {31'h0, if0.rd_valid}, {31'h0, erv});
    chk({tag, "_rv_wf"},   {31'h0, if1.rd_valid}, {31'h0, erv});
    chk({tag, "_oor"},     {31'h0, if0.oor}, {31'h0, eoor});
    chk({tag, "_busy"},    {31'h0, if0.busy}, {31'h0, ebusy});
  endtask

  task automatic set_in(input logic w, input logic [1:0] b, input logic [2:0] wa,
                        input logic [15:0] d, input logic r, input logic [2:0] ra);
    if0.wr = w; if0.be = b; if0.wraddr = wa; if0.din = d; if0.rd = r; if0.rdaddr = ra;
  endtask

  // Advance one edge, updating the model from the currently applied inputs.
  task automatic cycle(input string tag);
    logic [15:0] w;
    if (clr_left > 0) begin
      mm[8 - clr_left] = 16'h0;
      clr_left--;
      erv  = 1'b0;
      eoor = 1'b0;
    end else begin
      eoor = 1'b0;
      erv  = if0.rd;
      if (if0.rd) begin
        ed0 = mm[if0.rdaddr];
        ed1 = mm[if0.rdaddr];
        if (if0.wr && if0.wraddr == if0.rdaddr) begin
          w = mm[if0.rdaddr];
          for (int k = 0; k < 2; k++) if (if0.be[k]) w[8*k +: 8] = if0.din[8*k +: 8];
          ed1 = w;
        end
      end
      if (if0.wr) begin
        for (int k = 0; k < 2; k++)
          if (if0.be[k]) mm[if0.wraddr][8*k +: 8] = if0.din[8*k +: 8];
      end
    end
    ebusy = (clr_left > 0);
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    ed0 = 16'h0; ed1 = 16'h0; erv = 1'b0; eoor = 1'b0; ebusy = 1'b1;
    check_outs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_left = 8;
  endtask

  initial begin
    int n;
    rst  = 1'b1;
    rst2 = 1'b1;
    clr_left = 8;
    set_in(1'b0, 2'b00, 3'd0, 16'h0, 1'b0, 3'd0);
    if2.wr = 1'b0; if2.be = 2'b00; if2.wraddr = 3'd0; if2.din = 16'h0; if2.rd = 1'b0; if2.rdaddr = 3'd0;

    tbl[0] = '{1'b1, 2'b11, 3'd3, 16'hABCD, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 2'b01, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0};
    tbl[2] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd3, 16'hAB34, 16'hAB34, 1'b1};
    tbl[3] = '{1'b1, 2'b11, 3'd5, 16'h0F0F, 1'b0, 3'd0, 16'hAB34, 16'hAB34, 1'b0};
    tbl[4] = '{1'b1, 2'b10, 3'd5, 16'hFFFF, 1'b1, 3'd5, 16'h0F0F, 16'hFF0F, 1'b1};
    tbl[5] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd5, 16'hFF0F, 16'hFF0F, 1'b1};
    tbl[6] = '{1'b1, 2'b11, 3'd1, 16'h1111, 1'b1, 3'd3, 16'hAB34, 16'hAB34, 1'b1};
    tbl[7] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h1111, 16'h1111, 1'b1};
    tbl[8] = '{1'b1, 2'b00, 3'd1, 16'hFFFF, 1'b1, 3'd1, 16'h1111, 16'h1111, 1'b1};
    tbl[9] = '{1'b0, 2'b00, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h1111, 16'h1111, 1'b0};

    do_reset();

    // Requests during the first three clear edges are ignored
    set_in(1'b1, 2'b11, 3'd2, 16'h5555, 1'b1, 3'd2);
    n = 0;
    repeat (3) begin
      cycle("clr_req");
      n++;
    end
    set_in(1'b0, 2'b00, 3'd0, 16'h0, 1'b0, 3'd0);
    while (if0.busy && n < 20) begin
      cycle("clr_idle");
      n++;
    end
    chk("clear_edges", n, 8);

    for (int a = 0; a < 8; a++) begin
      set_in(1'b0, 2'b00, 3'd0, 16'h0, 1'b1, 3'(a));
      cycle("clr_read");
      chk("clr_read_zero", {16'h0, if0.dout}, 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].wr, tbl[i].be, tbl[i].wa, tbl[i].din, tbl[i].rd, tbl[i].ra);
      cycle("tbl_model");
      chk($sformatf("tbl%0d_dout_rf", i), {16'h0, if0.dout}, {16'h0, tbl[i].d0});
      chk($sformatf("tbl%0d_dout_wf", i), {16'h0, if1.dout}, {16'h0, tbl[i].d1});
      chk($sformatf("tbl%0d_rv", i), {31'h0, if0.rd_valid}, {31'h0, tbl[i].rv});
    end

    repeat (400) begin
      set_in(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      cycle("rand");
    end

    // Fill with nonzero data, then reset and confirm the clear wipes it
    for (int a = 0; a < 8; a++) begin
      set_in(1'b1, 2'b11, 3'(a), 16'hA5A0 | 16'(a), 1'b0, 3'd0);
      cycle("prefill");
    end
    set_in(1'b0, 2'b00, 3'd0, 16'h0, 1'b0, 3'd0);
    do_reset();
    n = 0;
    while (if0.busy && n < 20) begin
      cycle("reclr");
      n++;
    end
    chk("reclear_edges", n, 8);
    for (int a = 0; a < 8; a++) begin
      set_in(1'b0, 2'b00, 3'd0, 16'h0, 1'b1, 3'(a));
      cycle("reclr_read");
      chk("reclr_read_zero", {16'h0, if0.dout}, 32'h0);
    end
    set_in(1'b0, 2'b00, 3'd0, 16'h0, 1'b0, 3'd0);

    // Six-word instance: reset mid-clear, then out-of-range accesses
    rst2 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("u2_busy_pre", {31'h0, if2.busy}, 32'h1);
    end
    rst2 = 1'b1;
    #1;
    chk("u2_rst_busy", {31'h0, if2.busy}, 32'h1);
    chk("u2_rst_dout", {16'h0, if2.dout}, 32'h0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    n = 0;
    while (if2.busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("u2_clear_edges", n, 6);

    if2.wr = 1'b1; if2.be = 2'b11; if2.wraddr = 3'd7; if2.din = 16'h1234;
    @(posedge clk); #1;
    chk("u2_wr7_oor", {31'h0, if2.oor}, 32'h1);
    chk("u2_wr7_rv",  {31'h0, if2.rd_valid}, 32'h0);
    if2.wr = 1'b0; if2.rd = 1'b1; if2.rdaddr = 3'd7;
    @(posedge clk); #1;
    chk("u2_rd7_oor",  {31'h0, if2.oor}, 32'h1);
    chk("u2_rd7_rv",   {31'h0, if2.rd_valid}, 32'h1);
    chk("u2_rd7_dout", {16'h0, if2.dout}, 32'h0);
    if2.wr = 1'b1; if2.wraddr = 3'd4; if2.din = 16'h4444; if2.rdaddr = 3'd7;
    @(posedge clk); #1;
    chk("u2_mix_oor",  {31'h0, if2.oor}, 32'h1);
    chk("u2_mix_dout", {16'h0, if2.dout}, 32'h0);
    if2.wr = 1'b0; if2.rdaddr = 3'd4;
    @(posedge clk); #1;
    chk("u2_rd4_oor",  {31'h0, if2.oor}, 32'h0);
    chk("u2_rd4_rv",   {31'h0, if2.rd_valid}, 32'h1);
    chk("u2_rd4_dout", {16'h0, if2.dout}, 32'h4444);
    if2.rd = 1'b0;
    @(posedge clk); #1;
    chk("u2_idle_oor",  {31'h0, if2.oor}, 32'h0);
    chk("u2_idle_rv",   {31'h0, if2.rd_valid}, 32'h0);
    chk("u2_idle_dout", {16'h0, if2.dout}, 32'h4444);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
